// File: rtl/parking_lot_monitor.sv
// Multi-lane parking-lot monitor: one reversible entry/exit FSM per lane
// feeding a shared saturating occupancy counter with full/empty/sticky err.
module parking_lot_monitor #(
  parameter int LANES    = 2,
  parameter int CAPACITY = 16,
  parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic             clr_err,
  output logic [LANES-1:0] enter,
  output logic [LANES-1:0] exit,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam logic [2:0] S_EMPTY = 3'd0;
  localparam logic [2:0] S_IN1   = 3'd1;
  localparam logic [2:0] S_IN2   = 3'd2;
  localparam logic [2:0] S_IN3   = 3'd3;
  localparam logic [2:0] S_OUT1  = 3'd4;
  localparam logic [2:0] S_OUT2  = 3'd5;
  localparam logic [2:0] S_OUT3  = 3'd6;

  // Room for count plus/minus LANES with a sign bit to spare.
  localparam int SUM_W = CNT_W + $clog2(LANES + 1) + 2;
  localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

  logic [2:0]              state     [LANES];
  logic [2:0]              state_nxt [LANES];
  logic [LANES-1:0]        enter_raw;
  logic [LANES-1:0]        exit_raw;
  logic signed [SUM_W-1:0] delta;
  logic signed [SUM_W-1:0] cnt_sum;
  logic                    clamp;

  function automatic logic signed [SUM_W-1:0] popcount(input logic [LANES-1:0] v);
    logic signed [SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + signed'(SUM_W'(v[i]));
    return n;
  endfunction

  function automatic logic is_clamped(input logic signed [SUM_W-1:0] v);
    return (v > CAP_S) || v[SUM_W-1];
  endfunction

  function automatic logic [CNT_W-1:0] sat_count(input logic signed [SUM_W-1:0] v);
    if (v > CAP_S)   return CNT_W'(CAPACITY);
    if (v[SUM_W-1])  return '0;
    return v[CNT_W-1:0];
  endfunction

  always_comb begin
    enter_raw = '0;
    exit_raw  = '0;
    for (int i = 0; i < LANES; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        S_EMPTY: case ({a[i], b[i]})
          2'b10:   state_nxt[i] = S_IN1;
          2'b01:   state_nxt[i] = S_OUT1;
          default: ;
        endcase
        S_IN1: case ({a[i], b[i]})
          2'b11:        state_nxt[i] = S_IN2;
          2'b00, 2'b01: state_nxt[i] = S_EMPTY;
          default: ;
        endcase
        S_IN2: case ({a[i], b[i]})
          2'b01:   state_nxt[i] = S_IN3;
          2'b10:   state_nxt[i] = S_IN1;
          2'b00:   state_nxt[i] = S_EMPTY;
          default: ;
        endcase
        S_IN3: case ({a[i], b[i]})
          2'b00: begin
            state_nxt[i] = S_EMPTY;
            enter_raw[i] = 1'b1;
          end
          2'b11:   state_nxt[i] = S_IN2;
          default: ;
        endcase
        S_OUT1: case ({a[i], b[i]})
          2'b11:        state_nxt[i] = S_OUT2;
          2'b00, 2'b10: state_nxt[i] = S_EMPTY;
          default: ;
        endcase
        S_OUT2: case ({a[i], b[i]})
          2'b10:   state_nxt[i] = S_OUT3;
          2'b01:   state_nxt[i] = S_OUT1;
          2'b00:   state_nxt[i] = S_EMPTY;
          default: ;
        endcase
        S_OUT3: case ({a[i], b[i]})
          2'b00: begin
            state_nxt[i] = S_EMPTY;
            exit_raw[i]  = 1'b1;
          end
          2'b11:   state_nxt[i] = S_OUT2;
          default: ;
        endcase
        default: state_nxt[i] = S_EMPTY;
      endcase
    end
  end

  // Pulses are suppressed while reset is held so no event leaks out of reset.
  assign enter = enter_raw & {LANES{~reset}};
  assign exit  = exit_raw  & {LANES{~reset}};

  assign delta   = popcount(enter) - popcount(exit);
  assign cnt_sum = signed'(SUM_W'(count)) + delta;
  assign clamp   = is_clamped(cnt_sum);

  // Register stage: lane states, occupancy and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) state[i] <= S_EMPTY;
      count <= '0;
      err   <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) state[i] <= state_nxt[i];
      count <= sat_count(cnt_sum);
      err   <= clamp | (err & ~clr_err);
    end
  end

  assign full  = (count == CNT_W'(CAPACITY));
  assign empty = (count == '0);

endmodule

// File: tb/tb_parking_lot_monitor.sv
// Bench for parking_lot_monitor: directed scenarios then random sensor
// traffic, all compared against a progress-based behavioural model.
module tb_parking_lot_monitor;
  localparam int LANES = 2;
  localparam int CAP   = 16;
  localparam int CNT_W = $clog2(CAP + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [LANES-1:0] a = '0;
  logic [LANES-1:0] b = '0;
  logic             clr_err = 1'b0;
  logic [LANES-1:0] enter;
  logic [LANES-1:0] exit;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: prog[i] = how far a car has got (+1..+3 entering, -1..-3 leaving).
  int prog [LANES];
  int m_cnt = 0;
  bit m_err = 1'b0;

  parking_lot_monitor #(.LANES(LANES), .CAPACITY(CAP)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .clr_err(clr_err),
    .enter(enter), .exit(exit), .count(count),
    .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A passage is the pattern walk 10,11,01,00 (mirrored for exits); the car
  // may step forward, step back one, hold, or abandon the walk.
  function automatic void lane_step(input int p, input logic [1:0] ab,
                                    output int np, output bit en, output bit ex);
    logic [1:0] seq [4];
    logic [1:0] v;
    int k, sgn;
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    en = 1'b0; ex = 1'b0; np = p;
    if (p == 0) begin
      if (ab == seq[0]) np = 1;
      else if ({ab[0], ab[1]} == seq[0]) np = -1;
    end else begin
      sgn = (p > 0) ? 1 : -1;
      k   = (p > 0) ? p : -p;
      v   = (p > 0) ? ab : {ab[0], ab[1]};
      if (v == seq[k-1]) np = p;
      else if (v == seq[k]) begin
        if (k == 3) begin
          np = 0;
          if (sgn > 0) en = 1'b1; else ex = 1'b1;
        end else np = p + sgn;
      end
      else if (k >= 2 && v == seq[k-2]) np = p - sgn;
      else if (k < 3) np = 0;
    end
  endfunction

  task automatic step(input logic [1:0] ab0, input logic [1:0] ab1,
                      input logic clr, input logic rst);
    int np [LANES];
    logic [LANES-1:0] ee, ex;
    logic [1:0] abv [LANES];
    int nxt;
    abv[0] = ab0; abv[1] = ab1;
    a = {ab1[1], ab0[1]};
    b = {ab1[0], ab0[0]};
    clr_err = clr;
    reset = rst;
    for (int i = 0; i < LANES; i++) begin
      bit e1, x1;
      lane_step(prog[i], abv[i], np[i], e1, x1);
      ee[i] = e1 & ~rst;
      ex[i] = x1 & ~rst;
    end
    @(negedge clk);
    check("enter", 32'(enter), 32'(ee));
    check("exit",  32'(exit),  32'(ex));
    check("count", 32'(count), 32'(m_cnt));
    check("full",  32'(full),  32'(m_cnt == CAP));
    check("empty", 32'(empty), 32'(m_cnt == 0));
    check("err",   32'(err),   32'(m_err));
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < LANES; i++) prog[i] = 0;
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) prog[i] = np[i];
      nxt = m_cnt + $countones(ee) - $countones(ex);
      if (nxt > CAP) begin m_cnt = CAP; m_err = 1'b1; end
      else if (nxt < 0) begin m_cnt = 0; m_err = 1'b1; end
      else begin m_cnt = nxt; if (clr) m_err = 1'b0; end
    end
  endtask

  task automatic car(input int lane, input bit ent);
    logic [1:0] sq [4];
    if (ent) sq = '{2'b10, 2'b11, 2'b01, 2'b00};
    else     sq = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int k = 0; k < 4; k++) begin
      if (lane == 0) step(sq[k], 2'b00, 1'b0, 1'b0);
      else           step(2'b00, sq[k], 1'b0, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < LANES; i++) prog[i] = 0;
    @(posedge clk);
    #1;
    step(2'b00, 2'b00, 1'b0, 1'b1);
    step(2'b11, 2'b01, 1'b0, 1'b1);

    // Single entry on lane 0, single exit on lane 1
    car(0, 1'b1);
    check("t1_count", 32'(count), 32'd1);
    car(1, 1'b0);
    check("t2_count", 32'(count), 32'd0);
    check("t2_empty", 32'(empty), 32'd1);

    // Reversal mid-passage must not count
    step(2'b10, 2'b00, 1'b0, 1'b0);
    step(2'b11, 2'b00, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b0, 1'b0);
    step(2'b11, 2'b00, 1'b0, 1'b0);
    step(2'b10, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    check("t3_count", 32'(count), 32'd0);

    // Simultaneous entry and exit net to zero
    for (int n = 0; n < 5; n++) car(0, 1'b1);
    step(2'b10, 2'b01, 1'b0, 1'b0);
    step(2'b11, 2'b11, 1'b0, 1'b0);
    step(2'b01, 2'b10, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    check("t4_count", 32'(count), 32'd5);
    check("t4_err",   32'(err),   32'd0);

    // Saturation high, clear, then underflow
    for (int n = 0; n < 11; n++) car(0, 1'b1);
    check("t5_full", 32'(full), 32'd1);
    car(1, 1'b1);
    check("t5_sat_count", 32'(count), 32'd16);
    check("t5_sat_err",   32'(err),   32'd1);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    check("t5_clr", 32'(err), 32'd0);
    for (int n = 0; n < 16; n++) car(n % 2, 1'b0);
    check("t5_zero", 32'(count), 32'd0);
    car(0, 1'b0);
    check("t5_uf_err",   32'(err),   32'd1);
    check("t5_uf_count", 32'(count), 32'd0);

    // Reset while lane 0 sits one step before completing an entry
    car(1, 1'b1);
    step(2'b10, 2'b00, 1'b0, 1'b0);
    step(2'b11, 2'b00, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b0, 1'b1);
    check("t6_count", 32'(count), 32'd0);
    check("t6_err",   32'(err),   32'd0);
    step(2'b00, 2'b00, 1'b0, 1'b0);
    check("t6_no_enter", 32'(count), 32'd0);

    // Random sensor traffic
    for (int n = 0; n < 3000; n++) begin
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
